// File: rtl/voice_phase_osc.sv
// Single synth voice: phase accumulator, four waveforms, attack/sustain/release envelope.
// Optional macro VOICE_GATE_PHASE_RESET_EN zeroes the phase on every gate rise.
module voice_phase_osc #(
   parameter int ACC_W        = 16,
   parameter int ATTACK_STEP  = 8,
   parameter int RELEASE_STEP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic [15:0] increment,
   input  logic        gate,
   input  logic [1:0]  waveform,
   input  logic [7:0]  pulse_width,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        env_active
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ATTACK  = 2'd1;
   localparam logic [1:0] ST_SUSTAIN = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [8:0] ATT_STEP = 9'(ATTACK_STEP);
   localparam logic [7:0] REL_STEP = 8'(RELEASE_STEP);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       level_q, level_d;
   logic [1:0]       state_q, state_d;
   logic             gate_q;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             pend_q;
   logic [15:0]      sample_out_q, sample_out_d;
   logic             sample_valid_q;

   logic             rise, fall;
   logic [8:0]       level_sum;
   logic [7:0]       p;
   logic [6:0]       tri_v;
   logic signed [7:0] w;
   logic [15:0]      prod;

   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      level_sum = {1'b0, level_q} + ATT_STEP;
      if (rise) begin
         state_d = ST_ATTACK;
      end else if (fall && (state_q == ST_ATTACK || state_q == ST_SUSTAIN)) begin
         state_d = ST_RELEASE;
      end else if (sample_tick) begin
         case (state_q)
            ST_ATTACK: begin
               if (level_sum >= 9'd255) begin
                  level_d = 8'd255;
                  state_d = ST_SUSTAIN;
               end else begin
                  level_d = level_sum[7:0];
               end
            end
            ST_RELEASE: begin
               if (level_q <= REL_STEP) begin
                  level_d = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  level_d = level_q - REL_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      acc_d  = acc_q;
      lfsr_d = lfsr_q;
      if (sample_tick) begin
         acc_d  = acc_q + ACC_W'(increment);
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
`ifdef VOICE_GATE_PHASE_RESET_EN
      if (rise) acc_d = '0;
`endif
   end

   // Stage 2 reads the registers written by the tick one cycle earlier.
   always_comb begin
      p     = acc_q[ACC_W-1 -: 8];
      tri_v = p[7] ? ~p[6:0] : p[6:0];
      case (waveform)
         2'd0:    w = p - 8'd128;
         2'd1:    w = (p < pulse_width) ? 8'sd127 : -8'sd127;
         2'd2:    w = {tri_v, 1'b0} - 8'd128;
         default: w = lfsr_q[7:0];
      endcase
      prod         = {{8{w[7]}}, w} * {8'd0, level_q};
      sample_out_d = pend_q ? prod : sample_out_q;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q          <= '0;
         level_q        <= 8'd0;
         state_q        <= ST_IDLE;
         gate_q         <= 1'b0;
         lfsr_q         <= 16'hACE1;
         pend_q         <= 1'b0;
         sample_out_q   <= 16'd0;
         sample_valid_q <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         level_q        <= level_d;
         state_q        <= state_d;
         gate_q         <= gate;
         lfsr_q         <= lfsr_d;
         pend_q         <= sample_tick;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= pend_q;
      end
   end

   assign sample_out   = sample_out_q;
   assign sample_valid = sample_valid_q;
   assign env_active   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_voice_phase_osc.sv
// Self-checking bench for voice_phase_osc: two instances (16-bit fast envelope, 20-bit default
// envelope) share stimulus and are compared every cycle against a behavioural voice model.
module tb_voice_phase_osc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic [15:0] increment = 16'd0;
   logic        gate = 1'b0;
   logic [1:0]  waveform = 2'd0;
   logic [7:0]  pulse_width = 8'd0;
   logic [15:0] so [2];
   logic        sv [2];
   logic        ea [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   voice_phase_osc #(.ACC_W(16), .ATTACK_STEP(255), .RELEASE_STEP(100)) dut_a (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .increment(increment),
      .gate(gate), .waveform(waveform), .pulse_width(pulse_width),
      .sample_out(so[0]), .sample_valid(sv[0]), .env_active(ea[0])
   );

   voice_phase_osc #(.ACC_W(20), .ATTACK_STEP(8), .RELEASE_STEP(4)) dut_b (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .increment(increment),
      .gate(gate), .waveform(waveform), .pulse_width(pulse_width),
      .sample_out(so[1]), .sample_valid(sv[1]), .env_active(ea[1])
   );

   typedef enum int {M_IDLE, M_ATTACK, M_SUSTAIN, M_RELEASE} env_t;

   int   m_aw  [2] = '{16, 20};
   int   m_att [2] = '{255, 8};
   int   m_rel [2] = '{100, 4};
   int   m_acc [2];
   int   m_level [2];
   env_t m_env [2];
   int   m_lfsr [2];
   bit   m_pend [2];
   bit   m_gd [2];
   int   m_out [2];
   bit   m_valid [2];

   task automatic check(input string tag, input logic signed [31:0] got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wave_val(input int p, input int wf, input int pw, input int lf);
      int b;
      case (wf)
         0: return p - 128;
         1: return (p < pw) ? 127 : -127;
         2: return (p < 128) ? 2 * p - 128 : 2 * (255 - p) - 128;
         default: begin
            b = lf & 255;
            return (b >= 128) ? b - 256 : b;
         end
      endcase
   endfunction

   // Advances the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit rise, fall;
      int p, nb;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_acc[k] = 0; m_level[k] = 0; m_env[k] = M_IDLE; m_gd[k] = 0;
            m_lfsr[k] = 'hACE1; m_pend[k] = 0; m_out[k] = 0; m_valid[k] = 0;
         end else begin
            rise = gate && !m_gd[k];
            fall = !gate && m_gd[k];
            m_valid[k] = m_pend[k];
            if (m_pend[k]) begin
               p = m_acc[k] >> (m_aw[k] - 8);
               m_out[k] = wave_val(p, int'(waveform), int'(pulse_width), m_lfsr[k]) * m_level[k];
            end
            if (rise) m_env[k] = M_ATTACK;
            else if (fall && (m_env[k] == M_ATTACK || m_env[k] == M_SUSTAIN)) m_env[k] = M_RELEASE;
            else if (sample_tick) begin
               if (m_env[k] == M_ATTACK) begin
                  m_level[k] = (m_level[k] + m_att[k] > 255) ? 255 : m_level[k] + m_att[k];
                  if (m_level[k] == 255) m_env[k] = M_SUSTAIN;
               end else if (m_env[k] == M_RELEASE) begin
                  m_level[k] = (m_level[k] - m_rel[k] < 0) ? 0 : m_level[k] - m_rel[k];
                  if (m_level[k] == 0) m_env[k] = M_IDLE;
               end
            end
            if (sample_tick) begin
               m_acc[k] = (m_acc[k] + int'(increment)) % (1 << m_aw[k]);
               nb = ((m_lfsr[k] >> 15) ^ (m_lfsr[k] >> 13) ^ (m_lfsr[k] >> 12) ^ (m_lfsr[k] >> 10)) & 1;
               m_lfsr[k] = ((m_lfsr[k] << 1) | nb) & 'hFFFF;
            end
`ifdef VOICE_GATE_PHASE_RESET_EN
            if (rise) m_acc[k] = 0;
`endif
            m_pend[k] = sample_tick;
            m_gd[k]   = gate;
         end
      end
   endtask

   task automatic step_clk(input bit t);
      sample_tick = t;
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("out%0d", k), 32'($signed(so[k])), m_out[k]);
         check($sformatf("valid%0d", k), {31'd0, sv[k]}, int'(m_valid[k]));
         check($sformatf("env%0d", k), {31'd0, ea[k]}, (m_env[k] != M_IDLE) ? 1 : 0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step_clk(0);
      step_clk(0);
      reset = 1'b0;
   endtask

   initial begin
      // Noise right after reset: first LFSR step gives 16'h59C3, low byte -61.
      waveform = 2'd3;
      do_reset();
      gate = 1'b1;
      step_clk(0);
      step_clk(1);
      step_clk(0);
      check("noise_a", 32'($signed(so[0])), -15555);
      check("noise_b", 32'($signed(so[1])), -488);

      // Gate low: every tick still yields a zero sample two edges later.
      gate = 1'b0;
      waveform = 2'd0;
      increment = 16'h1234;
      do_reset();
      check("reset_out", 32'($signed(so[0])), 0);
      check("reset_env", {31'd0, ea[0]}, 0);
      for (int i = 0; i < 3; i++) begin
         step_clk(1);
         check("idle_valid_lat1", {31'd0, sv[0]}, 0);
         step_clk(0);
         check("idle_valid_lat2", {31'd0, sv[0]}, 1);
         check("idle_out", 32'($signed(so[0])), 0);
         check("idle_env", {31'd0, ea[0]}, 0);
      end

      // Attack to full in one step, then saw output.
      do_reset();
      increment = 16'h1000;
      gate = 1'b1;
      step_clk(0);
      step_clk(1);
      step_clk(0);
      check("attack_saw", 32'($signed(so[0])), -28560);
      check("attack_env", {31'd0, ea[0]}, 1);

      // Accumulator wrap: 0x1000 + 0xE000 = 0xF000, + 0x2000 wraps to 0x1000.
      increment = 16'hE000;
      step_clk(1);
      step_clk(0);
      check("acc_f000", 32'($signed(so[0])), 28560);
      increment = 16'h2000;
      step_clk(1);
      step_clk(0);
      check("acc_wrap", 32'($signed(so[0])), -28560);

      // Gate re-trigger coinciding with a tick.
      gate = 1'b0;
      step_clk(0);
      gate = 1'b1;
      increment = 16'h3000;
      step_clk(1);
      step_clk(0);
`ifdef VOICE_GATE_PHASE_RESET_EN
      check("retrig_phase", 32'($signed(so[0])), -32640);
`else
      check("retrig_phase", 32'($signed(so[0])), -16320);
`endif
      step_clk(1);
      step_clk(0);

      // Square across the duty threshold; gate held through reset gives a rise.
      gate = 1'b1;
      do_reset();
      step_clk(0);
      check("rise_after_reset", {31'd0, ea[0]}, 1);
      waveform = 2'd1;
      pulse_width = 8'h80;
      increment = 16'h7F00;
      step_clk(1);
      step_clk(0);
      check("square_hi", 32'($signed(so[0])), 32385);
      increment = 16'h0100;
      step_clk(1);
      step_clk(0);
      check("square_lo", 32'($signed(so[0])), -32385);

      // Release 255 -> 155 -> 55 -> 0, then IDLE.
      increment = 16'h0000;
      gate = 1'b0;
      step_clk(0);
      step_clk(1);
      step_clk(0);
      check("release_155", 32'($signed(so[0])), -19685);
      step_clk(1);
      step_clk(0);
      check("release_55", 32'($signed(so[0])), -6985);
      step_clk(1);
      check("release_idle_env", {31'd0, ea[0]}, 0);
      step_clk(0);
      check("release_zero", 32'($signed(so[0])), 0);
      check("release_zero_valid", {31'd0, sv[0]}, 1);

      // Back-to-back ticks give back-to-back valid pulses.
      for (int i = 0; i < 4; i++) begin
         step_clk(1);
         if (i > 0) check("b2b_valid", {31'd0, sv[0]}, 1);
      end
      step_clk(0);
      check("b2b_last", {31'd0, sv[0]}, 1);
      step_clk(0);
      check("b2b_done", {31'd0, sv[0]}, 0);

      // A pending result is dropped by reset.
      step_clk(1);
      reset = 1'b1;
      step_clk(0);
      reset = 1'b0;
      step_clk(0);
      check("rst_discard", {31'd0, sv[0]}, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         reset       = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 29) == 0) gate = ~gate;
         waveform    = 2'($urandom_range(0, 3));
         pulse_width = 8'($urandom);
         increment   = 16'($urandom);
         step_clk($urandom_range(0, 2) != 0);
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
